// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// PROG_LOADER_CHECKSUM_EN adds the trailing checksum state.
package prog_loader_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam int unsigned BYTE_W  = 8;

  // Bits of the INS_HI byte that must be zero.
  localparam logic [BYTE_W-1:0] INS_HI_RSVD_MASK = 8'hFE;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StInsLo,
    StInsHi,
`ifdef PROG_LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port out.
// master drives the stream and observes writes; slave is the loader.
interface prog_loader_if #(
  parameter int unsigned D = 12
);
  import prog_loader_pkg::*;

  logic [BYTE_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic               imem_wr_en;
  logic [D-1:0]       imem_wr_addr;
  logic [INSTR_W-1:0] imem_wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_wr_en, imem_wr_addr, imem_wr_data
  );

endinterface

// File: rtl/byte_assembler.sv
// Holds the INS_LO byte and merges it with bit 0 of the INS_HI byte;
// flags any nonzero reserved bit in the INS_HI byte.
module byte_assembler
  import prog_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               lo_we_i,
  input  logic [BYTE_W-1:0]  byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               rsvd_err_o
);

  logic [BYTE_W-1:0] lo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lo_q <= '0;
    end else if (lo_we_i) begin
      lo_q <= byte_i;
    end
  end

  assign word_o     = {byte_i[0], lo_q};
  assign rsvd_err_o = |(byte_i & INS_HI_RSVD_MASK);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: reassembles 9-bit instructions from a byte stream and writes them to
// sequential imem addresses, holding the core until done. Option: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned D = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  prog_loader_if.slave bus,
  output logic         core_hold_o,
  output logic         load_done_o,
  output logic         load_err_o
);

  loader_state_t      state_q, state_d;
  logic [D-1:0]       count_q, count_d;
  logic [D-1:0]       idx_q, idx_d;
  logic [D-1:0]       wr_addr_q, wr_addr_d;
  logic [INSTR_W-1:0] wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;
  logic               xfer, restart, lo_we, last_word, len_rsvd, ins_rsvd;
  logic [D-1:0]       len_full;
  logic [INSTR_W-1:0] word;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_t StEnd = StCsum;
  logic [BYTE_W-1:0] csum_q, csum_d;
  assign bus.in_ready = state_q inside {StLenLo, StLenHi, StInsLo, StInsHi, StCsum};
`else
  localparam loader_state_t StEnd = StDone;
  assign bus.in_ready = state_q inside {StLenLo, StLenHi, StInsLo, StInsHi};
`endif

  assign xfer      = bus.in_valid && bus.in_ready;
  assign restart   = start_i && (state_q inside {StIdle, StDone, StErr});
  assign len_full  = {bus.in_data[D-BYTE_W-1:0], count_q[BYTE_W-1:0]};
  assign len_rsvd  = |(bus.in_data >> (D - BYTE_W));
  assign last_word = (idx_q + D'(1)) == count_q;

  byte_assembler u_byte_assembler (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lo_we_i    (lo_we),
    .byte_i     (bus.in_data),
    .word_o     (word),
    .rsvd_err_o (ins_rsvd)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    lo_we     = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (restart) begin
          state_d   = StLenLo;
          count_d   = '0;
          idx_d     = '0;
          wr_addr_d = '0;
        end
      end
      StLenLo: begin
        if (xfer) begin
          count_d[BYTE_W-1:0] = bus.in_data;
          state_d             = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          count_d = len_full;
          if (len_rsvd)             state_d = StErr;
          else if (len_full == '0)  state_d = StEnd;
          else                      state_d = StInsLo;
        end
      end
      StInsLo: begin
        if (xfer) begin
          lo_we   = 1'b1;
          state_d = StInsHi;
        end
      end
      StInsHi: begin
        if (xfer) begin
          if (ins_rsvd) begin
            state_d = StErr;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = word;
            idx_d     = idx_q + D'(1);
            state_d   = last_word ? StEnd : StInsLo;
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StCsum: begin
        if (xfer) state_d = (bus.in_data == csum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      idx_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of every byte before the checksum byte itself.
  always_comb begin
    csum_d = csum_q;
    if (restart) begin
      csum_d = '0;
    end else if (xfer && state_q != StCsum) begin
      csum_d = csum_q ^ bus.in_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  assign bus.imem_wr_en   = wr_en_q;
  assign bus.imem_wr_addr = wr_addr_q;
  assign bus.imem_wr_data = wr_data_q;
  assign core_hold_o      = (state_q != StDone);
  assign load_done_o      = (state_q == StDone);
  assign load_err_o       = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a stream/expected-write model built from word lists,
// checked every cycle against the imem write port, plus literal pins.
`timescale 1ns/1ps
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int unsigned D = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic core_hold, load_done, load_err;

  prog_loader_if #(.D(D)) bus ();

  prog_loader #(.D(D)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .bus         (bus),
    .core_hold_o (core_hold),
    .load_done_o (load_done),
    .load_err_o  (load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ncyc    = 0;
  int last_ncyc = 0;
  int done_ncyc = -1;
  int err_ncyc  = -1;
  bit wr_at_done = 1'b0;
  bit done_prev  = 1'b0;
  bit err_prev   = 1'b0;

  logic [7:0]         stim_q[$];
  logic [D-1:0]       exp_addr_q[$];
  logic [INSTR_W-1:0] exp_data_q[$];
  logic [D-1:0]       log_addr[$];
  logic [INSTR_W-1:0] log_data[$];
  logic [INSTR_W-1:0] words[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected-write queue.
  initial begin
    logic [D-1:0]       ea;
    logic [INSTR_W-1:0] ed;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
        if (bus.imem_wr_en) begin
          log_addr.push_back(bus.imem_wr_addr);
          log_data.push_back(bus.imem_wr_data);
          check("write_expected", 32'(exp_data_q.size() > 0), 1);
          if (exp_data_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("wr_addr", 32'(bus.imem_wr_addr), 32'(ea));
            check("wr_data", 32'(bus.imem_wr_data), 32'(ed));
          end
        end
        check("hold_vs_done", 32'(core_hold), 32'(!load_done));
        if (load_done && !done_prev) begin
          done_ncyc  = ncyc;
          wr_at_done = bus.imem_wr_en;
        end
        if (load_err && !err_prev) err_ncyc = ncyc;
      end
      done_prev = load_done;
      err_prev  = load_err;
    end
  end

  // Model: byte stream and expected writes for a well-formed image of n words.
  task automatic build_good(input int n);
    logic [7:0] x;
    stim_q.delete();
    stim_q.push_back(n[7:0]);
    stim_q.push_back(8'(n >> 8));
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(words[i][7:0]);
      stim_q.push_back({7'b0, words[i][8]});
      exp_addr_q.push_back(D'(i));
      exp_data_q.push_back(words[i]);
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stim_q[k]) x ^= stim_q[k];
    stim_q.push_back(x);
`endif
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_stream(input bit toggle, input bit hold_start);
    bit ph = 1'b0;
    bit xf;
    int guard = 0;
    start = hold_start;
    while (stim_q.size() > 0 && guard < 400) begin
      bus.in_data  = stim_q[0];
      bus.in_valid = toggle ? ph : 1'b1;
      ph = !ph;
      xf = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (xf) begin
        void'(stim_q.pop_front());
        last_ncyc = ncyc;
      end
      #1;
      guard++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check("stream_consumed", 32'(stim_q.size()), 0);
  endtask

  task automatic finish_load(input string name, input bit exp_done, input int base,
                             input int nwr);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done"}, 32'(load_done), 32'(exp_done));
    check({name, "_err"}, 32'(load_err), 32'(!exp_done));
    check({name, "_hold"}, 32'(core_hold), 32'(!exp_done));
    check({name, "_nwrites"}, 32'(log_data.size() - base), 32'(nwr));
    check({name, "_pending"}, 32'(exp_data_q.size()), 0);
    if (exp_done) check({name, "_done_lat"}, 32'(done_ncyc), 32'(last_ncyc + 1));
    else          check({name, "_err_lat"}, 32'(err_ncyc), 32'(last_ncyc + 1));
    if (exp_done && nwr > 0) check({name, "_last_wr_with_done"}, 32'(wr_at_done), 1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_in_ready"}, 32'(bus.in_ready), 0);
    check({name, "_wr_en"}, 32'(bus.imem_wr_en), 0);
    check({name, "_wr_addr"}, 32'(bus.imem_wr_addr), 0);
    check({name, "_wr_data"}, 32'(bus.imem_wr_data), 0);
    check({name, "_hold"}, 32'(core_hold), 1);
    check({name, "_done"}, 32'(load_done), 0);
    check({name, "_err"}, 32'(load_err), 0);
  endtask

  initial begin
    int base;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    foreach (words[i]) words[i] = '0;

    #3;
    check_reset("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 0);

    // Three words, continuous valid.
    words[0] = 9'h1A5; words[1] = 9'h0FF; words[2] = 9'h100;
    base = log_data.size();
    build_good(3);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("cont", 1'b1, base, 3);
    if (log_data.size() >= base + 3) begin
      check("cont_pin_d0", 32'(log_data[base]), 32'h1A5);
      check("cont_pin_d1", 32'(log_data[base+1]), 32'h0FF);
      check("cont_pin_d2", 32'(log_data[base+2]), 32'h100);
      check("cont_pin_a0", 32'(log_addr[base]), 0);
      check("cont_pin_a2", 32'(log_addr[base+2]), 2);
    end

    // Same image, valid every other cycle, start held high while receiving.
    base = log_data.size();
    build_good(3);
    start_pulse();
    drive_stream(1'b1, 1'b1);
    finish_load("toggle", 1'b1, base, 3);

    // Reserved bit in second word's INS_HI: first word written, then ERR.
    base = log_data.size();
    stim_q = '{8'h02, 8'h00, 8'h55, 8'h00, 8'h77, 8'h03};
    exp_addr_q.push_back(D'(0));
    exp_data_q.push_back(9'h055);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("bad_hi", 1'b0, base, 1);

    // Recovery after ERR; address restarts at 0.
    words[0] = 9'h1FF;
    base = log_data.size();
    build_good(1);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("recover", 1'b1, base, 1);
    if (log_data.size() >= base + 1) begin
      check("recover_pin_d", 32'(log_data[base]), 32'h1FF);
      check("recover_pin_a", 32'(log_addr[base]), 0);
    end

    // LEN_HI with a reserved bit set.
    base = log_data.size();
    stim_q = '{8'h05, 8'h10};
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("len_rsvd", 1'b0, base, 0);

    // Empty image.
    base = log_data.size();
    build_good(0);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("zero", 1'b1, base, 0);

    // Reset while an INS_HI byte is on offer.
    base = log_data.size();
    stim_q = '{8'h02, 8'h00, 8'h11, 8'h00};
    exp_addr_q.push_back(D'(0));
    exp_data_q.push_back(9'h011);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    bus.in_data  = 8'h22;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_data = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk); #1;
    check("midrst_wr_en_held", 32'(bus.imem_wr_en), 0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_idle_ready", 32'(bus.in_ready), 0);
    check("midrst_idle_hold", 32'(core_hold), 1);
    check("midrst_nwrites", 32'(log_data.size() - base), 1);
    check("midrst_pending", 32'(exp_data_q.size()), 0);
    bus.in_valid = 1'b0;

    // Clean load after the reset.
    words[0] = 9'h001; words[1] = 9'h1FE;
    base = log_data.size();
    build_good(2);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("post_rst", 1'b1, base, 2);

`ifdef PROG_LOADER_CHECKSUM_EN
    words[0] = 9'h0AB;
    base = log_data.size();
    build_good(1);
    check("csum_model_pin", 32'(stim_q[4]), 32'hAA);
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("csum_ok", 1'b1, base, 1);

    base = log_data.size();
    build_good(1);
    stim_q[4] = 8'h00;
    start_pulse();
    drive_stream(1'b0, 1'b0);
    finish_load("csum_bad", 1'b0, base, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the 9-bit-instruction core. It receives a byte stream over a valid/ready handshake and writes each reassembled 9-bit instruction into the instruction memory's write port at sequential addresses. It holds the core in stall until the whole image is written and is the writer-side counterpart of the instruction fetch path (PC to instruction memory read).

## Interface
Parameters:
- D, 12 — instruction address width; it matches the PC width.

Ports:
- clk  in  1  — single system clock; all logic is on the rising edge.
- reset  in  1  — asynchronous, active-low reset.
- start  in  1  — one-cycle pulse that begins a load. It is honoured in IDLE, DONE and ERR, and ignored otherwise.
- in_data  in  8  — stream byte.
- in_valid  in  1  — in_data is valid.
- in_ready  out  1  — loader accepts a byte this cycle.
- imem_wr_en  out  1  — instruction memory write strobe.
- imem_wr_addr  out  D  — write address.
- imem_wr_data  out  9  — machine code word.
- core_hold  out  1  — stalls the PC and keeps the core from executing.
- load_done  out  1  — image fully written; sticky.
- load_err  out  1  — malformed stream; sticky.

## Operation
- A byte transfers on any cycle where in_valid && in_ready are both high.
- Stream format:
  - LEN_LO: count[7:0].
  - LEN_HI: count[D-1:8]; bits [7:D-8] of this byte must be 0.
  - Then count instructions, two bytes each:
    - INS_LO: word[7:0].
    - INS_HI: word[8] in bit 0; bits [7:1] must be 0.
- FSM states: IDLE, LEN_LO, LEN_HI, INS_LO, INS_HI, [CSUM], DONE, ERR.
  - IDLE → LEN_LO on start.
  - LEN_LO → LEN_HI on transfer.
  - LEN_HI → INS_LO on transfer.
    - If the reserved bits are nonzero, go to ERR instead.
    - If count == 0, go to CSUM if enabled, otherwise DONE.
  - INS_LO → INS_HI on transfer.
  - INS_HI → INS_LO on transfer.
    - If the reserved bits are nonzero, go to ERR.
    - After the last instruction, go to CSUM if enabled, otherwise DONE.
  - DONE or ERR → LEN_LO on start. Entering LEN_LO clears load_done, load_err, the address and the count.
- in_ready is 1 only in the LEN_LO, LEN_HI, INS_LO, INS_HI and CSUM states.
- Write address:
  - Starts at 0 and increments by 1 after each write.
  - The maximum image is 2^D−1 words, so the address never wraps within one load.
- Data written: imem_wr_data = {INS_HI[0], INS_LO byte}.
- core_hold:
  - 1 in every state except DONE.
  - Deasserts on the cycle DONE is entered, so the PC starts from its reset value 0. The PC reset is driven separately.
- Reset mid-load:
  - Returns to IDLE with core_hold = 1 and no write in flight.
  - The memory contents of the partial image are left undefined.

## Timing
- Reset values:
  - in_ready = 0, imem_wr_en = 0, imem_wr_addr = 0, imem_wr_data = 0.
  - core_hold = 1, load_done = 0, load_err = 0.
  - State = IDLE.
- Write latency:
  - imem_wr_en pulses high for exactly 1 cycle, on the cycle after the INS_HI transfer.
  - imem_wr_addr and imem_wr_data are registered and valid in that same cycle.
- Sustained throughput is 1 byte per cycle: in_ready stays high through the write-pulse cycle.
- load_done or load_err asserts on the cycle after the final accepted byte.
- The final write pulse and load_done occur in the same cycle.
- in_valid while in_ready = 0 is ignored; no byte is consumed.
- start coinciding with a transfer in a receive state is ignored; the transfer proceeds normally.

## Configuration
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last instruction (or after LEN_HI when count == 0), one CSUM byte follows.
  - CSUM must equal the XOR of all preceding bytes of the load, including the length bytes.
  - Match → DONE. Mismatch → ERR.
  - The running XOR is an 8-bit register cleared on entry to LEN_LO.
- Undefined:
  - There is no CSUM state and no XOR register.
  - The FSM goes directly to DONE.

## Structure
- Shared package prog_loader_pkg:
  - loader_state_t enum.
  - INSTR_W = 9.
  - BYTE_W = 8.
  - The reserved-bit mask for the INS_HI byte.
- Sub-module byte_assembler: latches the INS_LO byte, merges it with INS_HI bit 0, and flags nonzero reserved bits.
- The FSM, address counter and count comparator live in prog_loader.

## Test plan
- Count 3, words 0x1A5, 0x0FF, 0x100, continuous valid → 3 single-cycle writes at addresses 0, 1, 2 with exactly those values; load_done = 1 and core_hold = 0 in the cycle of the third write.
- The same stream with in_valid toggled every other cycle → identical writes; no byte is dropped or duplicated.
- INS_HI byte = 0x03 → ERR; load_err = 1, core_hold stays 1, no write occurs for that word; a later start followed by a good stream recovers.
- Count 0 → no writes; load_done occurs 1 cycle after the LEN_HI transfer (or after the CSUM transfer if enabled).
- Reset asserted (low) midway through an INS_HI → all outputs return to their reset values asynchronously and no write occurs; after release, state is IDLE.
- PROG_LOADER_CHECKSUM_EN, count 1, word 0x0AB: CSUM 0xAA (0x01^0x00^0xAB^0x00) → DONE; CSUM 0x00 → ERR.
